// File: rtl/cajero_controlador.sv
// cajero_controlador: ATM session controller sequencing PIN entry, lockout, and deposit/withdrawal balance updates.
// All outputs are registered; pulse outputs default low every cycle and are raised for exactly one edge.
module cajero_controlador #(
  parameter int PIN_DIGITS     = 4,
  parameter int MAX_INTENTOS   = 3,
  parameter int ADVERT_INTENTO = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        TARJETA_RECIBIDA,
  input  logic        TIPO_TRANS,
  input  logic        DIGITO_STB,
  input  logic [3:0]  DIGITO,
  input  logic [15:0] PIN,
  input  logic        MONTO_STB,
  input  logic [31:0] MONTO,
  input  logic [63:0] BALANCE_INICIAL,
  output logic [63:0] BALANCE,
  output logic        ENTREGAR_DINERO,
  output logic        PIN_INCORRECTO,
  output logic        ADVERTENCIA,
  output logic        BLOQUEO,
  output logic        FONDOS_INSUFICIENTES,
  output logic        BALANCE_ACTUALIZADO
);
  localparam int CW = $clog2(PIN_DIGITS + 1);
  localparam int FW = $clog2(MAX_INTENTOS + 1);
  typedef enum logic [2:0] {IDLE, PIN_ENTRY, CHECK_PIN, WAIT_MONTO, EXECUTE, BLOCKED} state_t;
  state_t        r_state;
  logic [15:0]   r_acc;
  logic [CW-1:0] r_cnt;
  logic [FW-1:0] r_fail;
  logic          r_tipo;
  logic [31:0]   r_monto;
  logic          w_digit_ok;
  logic          w_last_digit;
  logic [15:0]   w_acc_nx;
  logic [FW-1:0] w_fail_nx;
  logic [64:0]   w_sum;
  logic          w_fondos_ok;
  assign w_digit_ok   = DIGITO_STB && (DIGITO <= 4'd9);
  assign w_last_digit = r_cnt == CW'(PIN_DIGITS - 1);
  assign w_acc_nx     = r_acc * 16'd10 + {12'd0, DIGITO};
  assign w_fail_nx    = r_fail + 1'b1;
  assign w_sum        = {1'b0, BALANCE} + {33'd0, r_monto};
  assign w_fondos_ok  = {32'd0, r_monto} <= BALANCE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state              <= IDLE;
      r_acc                <= '0;
      r_cnt                <= '0;
      r_fail               <= '0;
      r_tipo               <= 1'b0;
      r_monto              <= '0;
      BALANCE              <= '0;
      ENTREGAR_DINERO      <= 1'b0;
      PIN_INCORRECTO       <= 1'b0;
      ADVERTENCIA          <= 1'b0;
      BLOQUEO              <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      BALANCE_ACTUALIZADO  <= 1'b0;
    end else begin
      ENTREGAR_DINERO      <= 1'b0;
      PIN_INCORRECTO       <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      BALANCE_ACTUALIZADO  <= 1'b0;
      case (r_state)
        IDLE: if (TARJETA_RECIBIDA && !BLOQUEO) begin
          BALANCE <= BALANCE_INICIAL;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= PIN_ENTRY;
        end
        PIN_ENTRY: if (!TARJETA_RECIBIDA) begin
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= IDLE;
        end else if (w_digit_ok) begin
          r_acc   <= w_acc_nx;
          r_cnt   <= r_cnt + 1'b1;
          r_state <= w_last_digit ? CHECK_PIN : PIN_ENTRY;
        end
        CHECK_PIN: if (r_acc == PIN) begin
          r_fail      <= '0;
          ADVERTENCIA <= 1'b0;
          r_tipo      <= TIPO_TRANS;
          r_state     <= WAIT_MONTO;
        end else begin
          r_fail         <= w_fail_nx;
          PIN_INCORRECTO <= 1'b1;
          r_acc          <= '0;
          r_cnt          <= '0;
          if (w_fail_nx == FW'(MAX_INTENTOS)) begin
            BLOQUEO     <= 1'b1;
            ADVERTENCIA <= 1'b0;
            r_state     <= BLOCKED;
          end else begin
            ADVERTENCIA <= (w_fail_nx == FW'(ADVERT_INTENTO)) ? 1'b1 : ADVERTENCIA;
            r_state     <= PIN_ENTRY;
          end
        end
        WAIT_MONTO: if (!TARJETA_RECIBIDA)
          r_state <= IDLE;
        else if (MONTO_STB) begin
          r_monto <= MONTO;
          r_state <= EXECUTE;
        end
        EXECUTE: begin
          r_state <= IDLE;
          if (!r_tipo) begin
            BALANCE             <= w_sum[64] ? '1 : w_sum[63:0];
            BALANCE_ACTUALIZADO <= 1'b1;
          end else if (w_fondos_ok) begin
            BALANCE             <= BALANCE - {32'd0, r_monto};
            ENTREGAR_DINERO     <= 1'b1;
            BALANCE_ACTUALIZADO <= 1'b1;
          end else
            FONDOS_INSUFICIENTES <= 1'b1;
        end
        BLOCKED: r_state <= BLOCKED;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cajero_controlador.sv
// tb_cajero_controlador: directed session scenarios for the ATM controller with hand-computed expectations.
module tb_cajero_controlador;
  logic        clk = 1'b0, rst = 1'b0;
  logic        tarjeta = 1'b0, tipo = 1'b0, dstb = 1'b0, mstb = 1'b0;
  logic [3:0]  digito = '0;
  logic [15:0] pin = 16'd1194;
  logic [31:0] monto = '0;
  logic [63:0] bal_ini = 64'd20000;
  logic [63:0] balance;
  logic        entregar, pin_inc, advert, bloqueo, fondos, act;
  int          n_cmp = 0, n_err = 0;
  cajero_controlador dut (
    .clk(clk), .rst(rst), .TARJETA_RECIBIDA(tarjeta), .TIPO_TRANS(tipo),
    .DIGITO_STB(dstb), .DIGITO(digito), .PIN(pin), .MONTO_STB(mstb), .MONTO(monto),
    .BALANCE_INICIAL(bal_ini), .BALANCE(balance), .ENTREGAR_DINERO(entregar),
    .PIN_INCORRECTO(pin_inc), .ADVERTENCIA(advert), .BLOQUEO(bloqueo),
    .FONDOS_INSUFICIENTES(fondos), .BALANCE_ACTUALIZADO(act)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic digit(input logic [3:0] d);
    digito = d;
    dstb = 1'b1;
    tick();
    dstb = 1'b0;
  endtask
  task automatic enter(input logic [3:0] a, b, c, d);
    digit(a); digit(b); digit(c); digit(d);
    tick();
  endtask
  task automatic insert();
    tarjeta = 1'b1;
    tick();
  endtask
  task automatic pay(input logic [31:0] m);
    monto = m;
    mstb = 1'b1;
    tick();
    mstb = 1'b0;
    tick();
  endtask
  task automatic eject();
    tarjeta = 1'b0;
    tick();
  endtask
  initial begin
    tick(); tick();
    chk("rst_balance", balance, 0);
    chk("rst_flags", {entregar, pin_inc, advert, bloqueo, fondos, act}, 0);
    rst = 1'b1;
    tipo = 1'b1;
    insert();
    chk("t1_load", balance, 64'd20000);
    enter(1, 1, 9, 4);
    chk("t1_pin_ok", pin_inc, 0);
    pay(32'd5000);
    chk("t1_entregar", entregar, 1);
    chk("t1_act", act, 1);
    chk("t1_balance", balance, 64'd15000);
    eject();
    chk("t1_pulse_end", {entregar, act}, 0);
    tipo = 1'b0;
    insert();
    enter(1, 1, 9, 4);
    pay(32'd3000);
    chk("t2_act", act, 1);
    chk("t2_entregar", entregar, 0);
    chk("t2_balance", balance, 64'd23000);
    eject();
    tipo = 1'b1;
    insert();
    enter(1, 1, 9, 4);
    pay(32'd25000);
    chk("t3_fondos", fondos, 1);
    chk("t3_no_dispense", {entregar, act}, 0);
    chk("t3_balance", balance, 64'd20000);
    eject();
    chk("t3_fondos_end", fondos, 0);
    bal_ini = 64'd5000;
    insert();
    enter(1, 1, 9, 4);
    pay(32'd5000);
    chk("eq_entregar", entregar, 1);
    chk("eq_balance", balance, 0);
    eject();
    bal_ini = 64'hFFFF_FFFF_FFFF_F000;
    tipo = 1'b0;
    insert();
    enter(1, 1, 9, 4);
    pay(32'h2000);
    chk("sat_act", act, 1);
    chk("sat_balance", balance, 64'hFFFF_FFFF_FFFF_FFFF);
    eject();
    bal_ini = 64'd20000;
    insert();
    enter(1, 1, 1, 1);
    chk("t4_inc1", pin_inc, 1);
    chk("t4_adv1", advert, 0);
    tick();
    chk("t4_inc1_end", pin_inc, 0);
    enter(1, 1, 1, 1);
    chk("t4_inc2", pin_inc, 1);
    chk("t4_adv2", advert, 1);
    digit(1); digit(4'd12); digit(1); digit(9); digit(4);
    tick();
    chk("t4_accept_inc", pin_inc, 0);
    chk("t4_adv_clr", advert, 0);
    pay(32'd100);
    chk("t4_balance", balance, 64'd20100);
    eject();
    insert();
    enter(1, 1, 1, 1);
    enter(2, 2, 2, 2);
    chk("t5_adv", advert, 1);
    enter(3, 3, 3, 3);
    chk("t5_inc3", pin_inc, 1);
    chk("t5_bloqueo", bloqueo, 1);
    chk("t5_adv_clr", advert, 0);
    eject();
    insert();
    enter(1, 1, 9, 4);
    pay(32'd500);
    chk("t5_sticky", bloqueo, 1);
    chk("t5_ignored", {entregar, act, pin_inc}, 0);
    chk("t5_balance", balance, 64'd20000);
    rst = 1'b0;
    #2;
    chk("t5_rst_bloqueo", bloqueo, 0);
    chk("t5_rst_balance", balance, 0);
    tarjeta = 1'b0;
    tick();
    rst = 1'b1;
    insert();
    digit(1); digit(1);
    eject();
    insert();
    enter(1, 1, 9, 4);
    chk("t6_accept", pin_inc, 0);
    chk("t6_balance", balance, 64'd20000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_rst_balance", balance, 0);
    chk("t6_rst_flags", {entregar, pin_inc, advert, bloqueo, fondos, act}, 0);
    rst = 1'b1;
    tarjeta = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
